// File: rtl/collatz_stopping_time.sv
// -----------------------------------------------------------------------------
// collatz_stopping_time
//
// Purpose:
//    Accepts a starting value n on an AXI-Stream input and applies the Collatz
//    step (n odd -> 3n+1, n even -> n/2) once per clock until n reaches 1.
//    Returns the step count, the peak value seen and a status code on an
//    AXI-Stream output. One item is processed at a time.
//
// Ports:
//    clk         clock, all logic on the rising edge
//    rst         synchronous active-high reset
//    num_TDATA   starting value n
//    num_TVALID  input valid
//    num_TREADY  input ready (registered)
//    res_TDATA   {peak, steps}, steps in the LSBs
//    res_TUSER   status: 00 ok, 01 overflow, 10 step limit, 11 zero input
//    res_TVALID  result valid (registered)
//    res_TREADY  result ready
// -----------------------------------------------------------------------------
module collatz_stopping_time #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16,
   parameter int MAX_STEPS  = 1000
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [DATA_WIDTH-1:0]           num_TDATA,
   input  logic                            num_TVALID,
   output logic                            num_TREADY,
   output logic [DATA_WIDTH+CNT_WIDTH-1:0] res_TDATA,
   output logic [1:0]                      res_TUSER,
   output logic                            res_TVALID,
   input  logic                            res_TREADY
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [1:0] ST_OK       = 2'b00;
   localparam logic [1:0] ST_OVERFLOW = 2'b01;
   localparam logic [1:0] ST_LIMIT    = 2'b10;
   localparam logic [1:0] ST_ZERO     = 2'b11;

   localparam logic [CNT_WIDTH-1:0]  MAX_CNT = CNT_WIDTH'(MAX_STEPS);
   localparam logic [CNT_WIDTH-1:0]  CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [DATA_WIDTH-1:0] N_ONE   = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [DATA_WIDTH+1:0] W_ONE   = {{(DATA_WIDTH+1){1'b0}}, 1'b1};

   state_t                  state_q,     state_d;
   logic [DATA_WIDTH-1:0]   n_q,         n_d;
   logic [CNT_WIDTH-1:0]    steps_q,     steps_d;
   logic [DATA_WIDTH-1:0]   peak_q,      peak_d;
   logic [1:0]              status_q,    status_d;
   logic                    num_ready_q, num_ready_d;
   logic                    res_valid_q, res_valid_d;

   // 3n+1 is formed two bits wider than n so that an overflow shows up as a
   // nonzero value in the top two bits instead of silently wrapping.
   logic [DATA_WIDTH+1:0]   n_ext;
   logic [DATA_WIDTH+1:0]   triple;
   logic                    triple_ovf;
   logic [DATA_WIDTH-1:0]   next_n;

   assign n_ext      = {2'b00, n_q};
   assign triple     = (n_ext << 1) + n_ext + W_ONE;
   assign triple_ovf = (triple[DATA_WIDTH+1:DATA_WIDTH] != 2'b00);
   assign next_n     = n_q[0] ? triple[DATA_WIDTH-1:0]
                              : {1'b0, n_q[DATA_WIDTH-1:1]};

   always_comb begin
      state_d     = state_q;
      n_d         = n_q;
      steps_d     = steps_q;
      peak_d      = peak_q;
      status_d    = status_q;
      num_ready_d = num_ready_q;
      res_valid_d = res_valid_q;

      case (state_q)
         IDLE: begin
            // Ready rises one cycle after reset release or after a result
            // is taken, so it never depends combinationally on an input.
            num_ready_d = 1'b1;
            if (num_ready_q && num_TVALID) begin
               n_d         = num_TDATA;
               steps_d     = '0;
               peak_d      = num_TDATA;
               num_ready_d = 1'b0;
               if (num_TDATA == '0) begin
                  status_d    = ST_ZERO;
                  res_valid_d = 1'b1;
                  state_d     = DONE;
               end else begin
                  status_d = ST_OK;
                  state_d  = RUN;
               end
            end
         end

         RUN: begin
            if (n_q == N_ONE) begin
               status_d    = ST_OK;
               res_valid_d = 1'b1;
               state_d     = DONE;
            end else if (steps_q == MAX_CNT) begin
               // Checked before the increment, so the counter cannot wrap.
               status_d    = ST_LIMIT;
               res_valid_d = 1'b1;
               state_d     = DONE;
            end else if (n_q[0] && triple_ovf) begin
               // steps/peak keep the values of the last completed step.
               status_d    = ST_OVERFLOW;
               res_valid_d = 1'b1;
               state_d     = DONE;
            end else begin
               n_d     = next_n;
               steps_d = steps_q + CNT_ONE;
               peak_d  = (next_n > peak_q) ? next_n : peak_q;
            end
         end

         DONE: begin
            if (res_TREADY) begin
               res_valid_d = 1'b0;
               num_ready_d = 1'b1;
               state_d     = IDLE;
            end
         end

         default: begin
            state_d     = IDLE;
            num_ready_d = 1'b0;
            res_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         n_q         <= '0;
         steps_q     <= '0;
         peak_q      <= '0;
         status_q    <= ST_OK;
         num_ready_q <= 1'b0;
         res_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         n_q         <= n_d;
         steps_q     <= steps_d;
         peak_q      <= peak_d;
         status_q    <= status_d;
         num_ready_q <= num_ready_d;
         res_valid_q <= res_valid_d;
      end
   end

   assign num_TREADY = num_ready_q;
   assign res_TVALID = res_valid_q;
   assign res_TDATA  = {peak_q, steps_q};
   assign res_TUSER  = status_q;

endmodule

// File: tb/tb_collatz_stopping_time.sv
// -----------------------------------------------------------------------------
// tb_collatz_stopping_time
//
// Three instances share one clock:
//    0: DATA_WIDTH=32, MAX_STEPS=1000
//    1: DATA_WIDTH=8,  MAX_STEPS=1000
//    2: DATA_WIDTH=32, MAX_STEPS=100
// A table of directed vectors is applied in a loop, followed by hand-written
// sequences for backpressure and reset during a computation.
// -----------------------------------------------------------------------------
module tb_collatz_stopping_time;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst        [3];
   logic [31:0] num_tdata  [3];
   logic        num_tvalid [3];
   logic        num_tready [3];
   logic [47:0] res_tdata  [3];
   logic [1:0]  res_tuser  [3];
   logic        res_tvalid [3];
   logic        res_tready [3];
   logic [23:0] res_tdata8;

   assign res_tdata[1] = {24'b0, res_tdata8};

   collatz_stopping_time #(.DATA_WIDTH(32), .CNT_WIDTH(16), .MAX_STEPS(1000)) dut0 (
      .clk(clk), .rst(rst[0]),
      .num_TDATA(num_tdata[0]), .num_TVALID(num_tvalid[0]), .num_TREADY(num_tready[0]),
      .res_TDATA(res_tdata[0]), .res_TUSER(res_tuser[0]),
      .res_TVALID(res_tvalid[0]), .res_TREADY(res_tready[0]));

   collatz_stopping_time #(.DATA_WIDTH(8), .CNT_WIDTH(16), .MAX_STEPS(1000)) dut1 (
      .clk(clk), .rst(rst[1]),
      .num_TDATA(num_tdata[1][7:0]), .num_TVALID(num_tvalid[1]), .num_TREADY(num_tready[1]),
      .res_TDATA(res_tdata8), .res_TUSER(res_tuser[1]),
      .res_TVALID(res_tvalid[1]), .res_TREADY(res_tready[1]));

   collatz_stopping_time #(.DATA_WIDTH(32), .CNT_WIDTH(16), .MAX_STEPS(100)) dut2 (
      .clk(clk), .rst(rst[2]),
      .num_TDATA(num_tdata[2]), .num_TVALID(num_tvalid[2]), .num_TREADY(num_tready[2]),
      .res_TDATA(res_tdata[2]), .res_TUSER(res_tuser[2]),
      .res_TVALID(res_tvalid[2]), .res_TREADY(res_tready[2]));

   typedef struct {
      int          idx;
      logic [31:0] n;
      logic [15:0] steps;
      logic [31:0] peak;
      logic [1:0]  status;
      int          lat;     // -1: latency not checked
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] get_peak(input int idx);
      if (idx == 1) return {24'b0, res_tdata[1][23:16]};
      return res_tdata[idx][47:16];
   endfunction

   function automatic logic [15:0] get_steps(input int idx);
      return res_tdata[idx][15:0];
   endfunction

   task automatic accept(input int idx, input logic [31:0] n);
      int k = 0;
      while (!num_tready[idx] && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      check("input_ready_wait", {47'b0, num_tready[idx]}, 48'd1);
      num_tdata[idx]  = n;
      num_tvalid[idx] = 1'b1;
      @(posedge clk); #1;
      num_tvalid[idx] = 1'b0;
      num_tdata[idx]  = 32'hDEAD_BEEF;
   endtask

   // lat = k means res_TVALID is first sampled high at edge t+k.
   task automatic wait_result(input int idx, output int lat);
      lat = 1;
      while (!res_tvalid[idx] && lat < 3000) begin
         @(posedge clk); #1;
         lat++;
      end
      check("result_valid_timeout", {47'b0, res_tvalid[idx]}, 48'd1);
   endtask

   task automatic run_item(input int idx, input logic [31:0] n, input logic [15:0] es,
                           input logic [31:0] ep, input logic [1:0] est, input int elat);
      int lat;
      res_tready[idx] = 1'b1;
      accept(idx, n);
      wait_result(idx, lat);
      $display("inst%0d n=%0d -> steps=%0d peak=%0d status=%0d lat=%0d",
               idx, n, get_steps(idx), get_peak(idx), res_tuser[idx], lat);
      check("steps",  {32'b0, get_steps(idx)}, {32'b0, es});
      check("peak",   {16'b0, get_peak(idx)},  {16'b0, ep});
      check("status", {46'b0, res_tuser[idx]}, {46'b0, est});
      if (elat >= 0) check("latency", 48'(lat), 48'(elat));
      @(posedge clk); #1;
      check("valid_after_take", {47'b0, res_tvalid[idx]}, 48'd0);
      check("ready_after_take", {47'b0, num_tready[idx]}, 48'd1);
   endtask

   initial begin
      logic [47:0] held_data;
      logic [1:0]  held_user;
      int          lat;

      for (int i = 0; i < 3; i++) begin
         rst[i]        = 1'b1;
         num_tdata[i]  = '0;
         num_tvalid[i] = 1'b0;
         res_tready[i] = 1'b1;
      end

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         check("reset_num_ready", {47'b0, num_tready[i]}, 48'd0);
         check("reset_res_valid", {47'b0, res_tvalid[i]}, 48'd0);
         check("reset_res_data",  res_tdata[i], 48'd0);
         check("reset_res_user",  {46'b0, res_tuser[i]}, 48'd0);
         rst[i] = 1'b0;
      end
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++)
         check("ready_after_reset", {47'b0, num_tready[i]}, 48'd1);
      $display("reset released, num_TREADY high on all instances");

      // Directed vectors
      vecs.push_back('{0, 32'd6,          16'd8,   32'd16,         2'b00, 10});
      vecs.push_back('{0, 32'd27,         16'd111, 32'd9232,       2'b00, 113});
      vecs.push_back('{0, 32'd1,          16'd0,   32'd1,          2'b00, 2});
      vecs.push_back('{0, 32'd2,          16'd1,   32'd2,          2'b00, 3});
      vecs.push_back('{0, 32'd3,          16'd7,   32'd16,         2'b00, 9});
      vecs.push_back('{0, 32'd0,          16'd0,   32'd0,          2'b11, 1});
      vecs.push_back('{0, 32'h5555_5555,  16'd0,   32'h5555_5555,  2'b01, 2});
      vecs.push_back('{0, 32'hFFFF_FFFF,  16'd0,   32'hFFFF_FFFF,  2'b01, 2});
      vecs.push_back('{1, 32'd255,        16'd0,   32'd255,        2'b01, 2});
      vecs.push_back('{1, 32'd0,          16'd0,   32'd0,          2'b11, 1});
      vecs.push_back('{1, 32'd27,         16'd11,  32'd214,        2'b01, 13});
      vecs.push_back('{1, 32'd7,          16'd16,  32'd52,         2'b00, 18});
      vecs.push_back('{2, 32'd27,         16'd100, 32'd9232,       2'b10, 102});
      vecs.push_back('{2, 32'd6,          16'd8,   32'd16,         2'b00, 10});
      vecs.push_back('{2, 32'd1,          16'd0,   32'd1,          2'b00, 2});

      foreach (vecs[v])
         run_item(vecs[v].idx, vecs[v].n, vecs[v].steps, vecs[v].peak,
                  vecs[v].status, vecs[v].lat);

      // Backpressure: result held for 20 cycles, second input ignored
      res_tready[0] = 1'b0;
      accept(0, 32'd6);
      wait_result(0, lat);
      held_data = res_tdata[0];
      held_user = res_tuser[0];
      check("bp_steps", {32'b0, held_data[15:0]}, 48'd8);
      for (int i = 0; i < 20; i++) begin
         if (i == 3) begin
            num_tdata[0]  = 32'd3;
            num_tvalid[0] = 1'b1;
         end
         if (i == 6) num_tvalid[0] = 1'b0;
         @(posedge clk); #1;
         check("bp_data_stable", res_tdata[0], held_data);
         check("bp_user_stable", {46'b0, res_tuser[0]}, {46'b0, held_user});
         check("bp_num_ready_low", {47'b0, num_tready[0]}, 48'd0);
         check("bp_valid_held", {47'b0, res_tvalid[0]}, 48'd1);
      end
      $display("backpressure: held steps=%0d for 20 cycles", held_data[15:0]);
      res_tready[0] = 1'b1;
      @(posedge clk); #1;
      check("bp_valid_drop", {47'b0, res_tvalid[0]}, 48'd0);
      check("bp_ready_rise", {47'b0, num_tready[0]}, 48'd1);
      run_item(0, 32'd7, 16'd16, 32'd52, 2'b00, 18);

      // Reset during RUN: in-flight item discarded
      accept(0, 32'd27);
      repeat (4) @(posedge clk);
      #1;
      rst[0] = 1'b1;
      @(posedge clk); #1;
      check("midrst_valid", {47'b0, res_tvalid[0]}, 48'd0);
      check("midrst_ready", {47'b0, num_tready[0]}, 48'd0);
      check("midrst_data",  res_tdata[0], 48'd0);
      check("midrst_user",  {46'b0, res_tuser[0]}, 48'd0);
      rst[0] = 1'b0;
      @(posedge clk); #1;
      check("midrst_ready_rise", {47'b0, num_tready[0]}, 48'd1);
      for (int i = 0; i < 120; i++) begin
         if (res_tvalid[0]) check("midrst_no_result", {47'b0, res_tvalid[0]}, 48'd0);
         @(posedge clk); #1;
      end
      check("midrst_still_idle", {47'b0, res_tvalid[0]}, 48'd0);
      $display("reset mid-run: no result emitted");
      run_item(0, 32'd6, 16'd8, 32'd16, 2'b00, 10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/collatz_stopping_time.md
Name: collatz_stopping_time

Overview:
Multi-cycle, parametrised successor to the single-step Collatz block. It accepts a number n on an AXI-Stream input and iterates the Collatz function until n reaches 1, one step per clock. It returns the step count, the peak value reached and a status code on an AXI-Stream output. It sits between the stream driver and the debug-guv-instrumented downstream logic, and processes one number at a time.

Parameters:
DATA_WIDTH  32    width of n and of every intermediate value
CNT_WIDTH   16    width of the step counter; must satisfy CNT_WIDTH >= clog2(MAX_STEPS+1)
MAX_STEPS   1000  step limit; reaching it aborts with status "limit"

Ports:
clk         in   1                     clock, all logic on rising edge
rst         in   1                     synchronous, active-high reset
num_TDATA   in   DATA_WIDTH            starting value n
num_TVALID  in   1                     input valid
num_TREADY  out  1                     input ready (registered)
res_TDATA   out  DATA_WIDTH+CNT_WIDTH  {peak, steps}, with steps in the LSBs
res_TUSER   out  2                     status: 00 ok, 01 overflow, 10 limit, 11 zero input
res_TVALID  out  1                     result valid (registered)
res_TREADY  in   1                     result ready

Behaviour:
- Reset (rst high at a clock edge):
  - state goes to IDLE; num_TREADY=0, res_TVALID=0, res_TDATA=0, res_TUSER=0.
  - num_TREADY rises on the first clock after rst deasserts.
  - Reset asserted mid-computation or mid-output discards the in-flight item; no result is emitted.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - num_TREADY=1. A handshake at edge t latches n, sets steps=0 and peak=n, and drops num_TREADY.
  - If n==0: go to DONE with steps=0, peak=0, status 11; res_TVALID is high from t+1.
  - Otherwise go to RUN.
- RUN, evaluated each cycle in this priority order:
  1. If n==1: go to DONE, status 00.
  2. Else if steps==MAX_STEPS: go to DONE, status 10.
  3. Else if n is odd and 3n+1 does not fit in DATA_WIDTH bits (use a DATA_WIDTH+2-bit intermediate): go to DONE, status 01. steps and peak are left unchanged and count only completed steps.
  4. Else: n <= (odd ? 3n+1 : n>>1), steps <= steps+1, peak <= max(peak, new n).
- Latency: for a nonzero input accepted at edge t, res_TVALID goes high at t+2+S, where S = number of steps performed (an input of 1 gives S=0, so t+2). Throughput is one item per S+3 cycles minimum.
- DONE:
  - res_TVALID=1; res_TDATA and res_TUSER are held stable while res_TREADY=0.
  - A handshake at edge u returns the FSM to IDLE. res_TVALID=0 and num_TREADY=1 from u+1.
- No combinational path exists from res_TREADY to res_TVALID, or from any input to num_TREADY; all handshake outputs come directly from flops.
- num_TVALID/num_TDATA activity while num_TREADY=0 is ignored.
- The counter never wraps: the MAX_STEPS check precedes the increment.

Test Plan:
1. DATA_WIDTH=32: send n=6, hold res_TREADY=1 -> steps=8, peak=16, status 00; res_TVALID high 10 cycles after the input handshake.
2. DATA_WIDTH=32: send n=27 -> steps=111, peak=9232, status 00. Then send n=1 -> steps=0, peak=1, status 00, res_TVALID high 2 cycles after acceptance.
3. DATA_WIDTH=8: send n=255 -> steps=0, peak=255, status 01. Send n=0 -> steps=0, peak=0, status 11, res_TVALID high 1 cycle after acceptance.
4. MAX_STEPS=100: send n=27 -> steps=100, status 10. Send n=6 -> steps=8, status 00.
5. Backpressure: hold res_TREADY=0 for 20 cycles after res_TVALID rises -> res_TDATA/res_TUSER stable, num_TREADY=0 throughout, and a second num_TVALID pulse is not accepted. Release res_TREADY -> num_TREADY=1 on the following cycle.
6. Reset mid-RUN: assert rst 5 cycles after accepting n=27 -> outputs are 0 on the next edge and no result is emitted. After release, num_TREADY rises one cycle later, and a fresh n=6 gives steps=8.
